// File: rtl/nanosoc_busmatrix_input_stage.sv
// Bus matrix input stage: a one-entry holding register between an AHB master port and the decoder/arbiters.
// Compile option NANOSOC_INPUT_STAGE_SEQ_TO_NONSEQ_EN re-presents held SEQ beats as NONSEQ/INCR.
module nanosoc_busmatrix_input_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELS,
  input  logic [1:0]        HTRANSS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  output logic [1:0]        TRANSM,
  output logic [ADDR_W-1:0] ADDRM,
  output logic              WRITEM,
  output logic [2:0]        SIZEM,
  output logic [2:0]        BURSTM,
  output logic [3:0]        PROTM,
  output logic              MASTLOCKM,
  input  logic              active_dec,
  input  logic              readyout_dec,
  input  logic              resp_dec
);

  localparam logic [1:0] TRANS_IDLE = 2'b00;

  logic              pend;
  logic              data_phase;
  logic [1:0]        reg_trans;
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_write;
  logic [2:0]        reg_size;
  logic [2:0]        reg_burst;
  logic [3:0]        reg_prot;
  logic              reg_mastlock;

  logic              valid_in;
  logic              accept;
  logic              capture;
  logic [1:0]        held_trans;
  logic [2:0]        held_burst;

  assign valid_in = HSELS & HTRANSS[1] & HREADYS;
  assign accept   = active_dec & readyout_dec;
  assign capture  = valid_in & ~pend & ~accept;

`ifdef NANOSOC_INPUT_STAGE_SEQ_TO_NONSEQ_EN
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_INCR   = 3'b001;

  // A held beat may be issued after the slave lost burst context, so restart it as an undefined-length burst.
  assign held_trans = (reg_trans == TRANS_SEQ) ? TRANS_NONSEQ : reg_trans;
  assign held_burst = (reg_trans == TRANS_SEQ) ? BURST_INCR : reg_burst;
`else
  assign held_trans = reg_trans;
  assign held_burst = reg_burst;
`endif

  assign TRANSM    = pend ? held_trans   : (HSELS ? HTRANSS : TRANS_IDLE);
  assign ADDRM     = pend ? reg_addr     : HADDRS;
  assign WRITEM    = pend ? reg_write    : HWRITES;
  assign SIZEM     = pend ? reg_size     : HSIZES;
  assign BURSTM    = pend ? held_burst   : HBURSTS;
  assign PROTM     = pend ? reg_prot     : HPROTS;
  assign MASTLOCKM = pend ? reg_mastlock : HMASTLOCKS;

  // Outside a data phase the only reason to stall the master is an unissued held transfer.
  assign HREADYOUTS = data_phase ? readyout_dec : ~pend;
  assign HRESPS     = data_phase & resp_dec;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend         <= 1'b0;
      data_phase   <= 1'b0;
      reg_trans    <= '0;
      reg_addr     <= '0;
      reg_write    <= 1'b0;
      reg_size     <= '0;
      reg_burst    <= '0;
      reg_prot     <= '0;
      reg_mastlock <= 1'b0;
    end else begin
      if (capture) begin
        pend         <= 1'b1;
        reg_trans    <= HTRANSS;
        reg_addr     <= HADDRS;
        reg_write    <= HWRITES;
        reg_size     <= HSIZES;
        reg_burst    <= HBURSTS;
        reg_prot     <= HPROTS;
        reg_mastlock <= HMASTLOCKS;
      end else if (pend && accept) begin
        pend <= 1'b0;
      end

      if (accept && TRANSM[1]) begin
        data_phase <= 1'b1;
      end else if (readyout_dec) begin
        data_phase <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nanosoc_busmatrix_input_stage.sv
// Directed self-checking bench for nanosoc_busmatrix_input_stage.
// Expectations follow NANOSOC_INPUT_STAGE_SEQ_TO_NONSEQ_EN when the bench is built with it defined.
module tb_nanosoc_busmatrix_input_stage;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS;
  logic [1:0]  HTRANSS;
  logic [31:0] HADDRS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic        HRESPS;
  logic [1:0]  TRANSM;
  logic [31:0] ADDRM;
  logic        WRITEM;
  logic [2:0]  SIZEM;
  logic [2:0]  BURSTM;
  logic [3:0]  PROTM;
  logic        MASTLOCKM;
  logic        active_dec;
  logic        readyout_dec;
  logic        resp_dec;

  int checks = 0;
  int errors = 0;

  nanosoc_busmatrix_input_stage #(.ADDR_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSELS(HSELS), .HTRANSS(HTRANSS), .HADDRS(HADDRS), .HWRITES(HWRITES),
    .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS),
    .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .TRANSM(TRANSM), .ADDRM(ADDRM), .WRITEM(WRITEM), .SIZEM(SIZEM),
    .BURSTM(BURSTM), .PROTM(PROTM), .MASTLOCKM(MASTLOCKM),
    .active_dec(active_dec), .readyout_dec(readyout_dec), .resp_dec(resp_dec)
  );

  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                               input logic [2:0] burst, input logic write, input logic lock,
                               input logic hready, input logic act, input logic rdy, input logic resp);
    HSELS        = sel;
    HTRANSS      = trans;
    HADDRS       = addr;
    HBURSTS      = burst;
    HWRITES      = write;
    HMASTLOCKS   = lock;
    HREADYS      = hready;
    active_dec   = act;
    readyout_dec = rdy;
    resp_dec     = resp;
    #3;
  endtask

  task automatic nextCycle();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HSIZES  = 3'b010;
    HPROTS  = 4'b0011;
    HRESETn = 1'b0;
    applyStimulus(1'b0, IDLE, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("reset_hreadyout", HREADYOUTS, 1);
    checkOutput("reset_hresp", HRESPS, 0);
    checkOutput("reset_trans", TRANSM, IDLE);
    #7 HRESETn = 1'b1;
    nextCycle();

    // Pass-through NONSEQ accepted immediately
    applyStimulus(1'b1, NONSEQ, 32'h2000_0000, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("pt_trans", TRANSM, NONSEQ);
    checkOutput("pt_addr", ADDRM, 32'h2000_0000);
    checkOutput("pt_hreadyout", HREADYOUTS, 1);
    nextCycle();
    applyStimulus(1'b0, IDLE, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("pt_dphase_wait", HREADYOUTS, 0);
    checkOutput("pt_no_pend_trans", TRANSM, IDLE);
    nextCycle();
    applyStimulus(1'b0, IDLE, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("pt_dphase_done", HREADYOUTS, 1);
    nextCycle();

    // NONSEQ held while the arbiter withholds grant
    applyStimulus(1'b1, NONSEQ, 32'h4000_0010, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("hold_offer_hreadyout", HREADYOUTS, 1);
    checkOutput("hold_offer_addr", ADDRM, 32'h4000_0010);
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      applyStimulus(1'b1, NONSEQ, 32'h5555_0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("hold_wait_hreadyout", HREADYOUTS, 0);
      checkOutput("hold_wait_addr", ADDRM, 32'h4000_0010);
      checkOutput("hold_wait_trans", TRANSM, NONSEQ);
      checkOutput("hold_wait_lock", MASTLOCKM, 1);
      checkOutput("hold_wait_write", WRITEM, 1);
    end
    nextCycle();
    applyStimulus(1'b1, NONSEQ, 32'h5555_0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("hold_issue_hreadyout", HREADYOUTS, 0);
    checkOutput("hold_issue_addr", ADDRM, 32'h4000_0010);
    checkOutput("hold_issue_trans", TRANSM, NONSEQ);
    nextCycle();
    applyStimulus(1'b0, IDLE, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("hold_released_hreadyout", HREADYOUTS, 1);
    checkOutput("hold_released_trans", TRANSM, IDLE);
    checkOutput("hold_released_lock", MASTLOCKM, 0);
    nextCycle();

    // Held SEQ beat of an INCR4 burst
    applyStimulus(1'b1, SEQ, 32'h4000_0014, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("seq_offer_trans", TRANSM, SEQ);
    checkOutput("seq_offer_burst", BURSTM, 3'b011);
    nextCycle();
    applyStimulus(1'b1, NONSEQ, 32'h7000_0000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef NANOSOC_INPUT_STAGE_SEQ_TO_NONSEQ_EN
    checkOutput("seq_held_trans", TRANSM, NONSEQ);
    checkOutput("seq_held_burst", BURSTM, 3'b001);
`else
    checkOutput("seq_held_trans", TRANSM, SEQ);
    checkOutput("seq_held_burst", BURSTM, 3'b011);
`endif
    checkOutput("seq_held_addr", ADDRM, 32'h4000_0014);
    checkOutput("seq_held_hreadyout", HREADYOUTS, 0);
    nextCycle();
    applyStimulus(1'b1, NONSEQ, 32'h7000_0000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("seq_issue_addr", ADDRM, 32'h4000_0014);
    nextCycle();

    // Two-cycle ERROR from the downstream slave
    applyStimulus(1'b0, IDLE, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("err1_hresp", HRESPS, 1);
    checkOutput("err1_hreadyout", HREADYOUTS, 0);
    nextCycle();
    applyStimulus(1'b0, IDLE, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("err2_hresp", HRESPS, 1);
    checkOutput("err2_hreadyout", HREADYOUTS, 1);
    nextCycle();
    applyStimulus(1'b0, IDLE, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("resp_outside_dphase", HRESPS, 0);
    nextCycle();

    // BUSY and deselected NONSEQ must not be captured
    applyStimulus(1'b1, BUSY, 32'h3000_0000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("busy_trans", TRANSM, BUSY);
    checkOutput("busy_hreadyout", HREADYOUTS, 1);
    nextCycle();
    applyStimulus(1'b0, NONSEQ, 32'h3000_0004, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("busy_not_held_hreadyout", HREADYOUTS, 1);
    checkOutput("unsel_trans", TRANSM, IDLE);
    nextCycle();
    applyStimulus(1'b0, IDLE, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("unsel_not_held_hreadyout", HREADYOUTS, 1);
    nextCycle();

    // Asynchronous reset while a transfer is held
    applyStimulus(1'b1, NONSEQ, 32'h6000_0000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, IDLE, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("rst_hold_hreadyout", HREADYOUTS, 0);
    checkOutput("rst_hold_addr", ADDRM, 32'h6000_0000);
    checkOutput("rst_hold_trans", TRANSM, NONSEQ);
    #1 HRESETn = 1'b0;
    #1;
    checkOutput("rst_async_hreadyout", HREADYOUTS, 1);
    checkOutput("rst_async_trans", TRANSM, IDLE);
    checkOutput("rst_async_hresp", HRESPS, 0);
    #1 HRESETn = 1'b1;
    nextCycle();
    applyStimulus(1'b0, IDLE, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("rst_discard_hreadyout", HREADYOUTS, 1);
    checkOutput("rst_discard_trans", TRANSM, IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
